// File: rtl/sw_debounce_pkg.sv
// Shared definitions for the switch debouncer.
//   ST_IDLE / ST_COUNT : per-bit FSM state encoding
//   cnt_width()        : width of the per-bit persistence counter
package sw_debounce_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_COUNT = 1'b1;

    // The counter only ever reaches cycles-1, so $clog2(cycles) bits are enough.
    // The floor of 1 keeps the vector legal for degenerate parameter values.
    function automatic int cnt_width(input int cycles);
        int w;
        w = $clog2(cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: 2-flop synchroniser, IDLE/COUNT persistence filter and
// one-cycle edge pulses.
//   clk, RSTn  : clock, asynchronous active-low reset
//   sw_raw     : asynchronous switch pin
//   sw_stable  : debounced level (registered)
//   sw_rise    : pulse in the cycle sw_stable becomes 1
//   sw_fall    : pulse in the cycle sw_stable becomes 0
module debounce_bit
    import sw_debounce_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = 500000,
    parameter logic INIT_VAL        = 1'b0
) (
    input  logic clk,
    input  logic RSTn,
    input  logic sw_raw,
    output logic sw_stable,
    output logic sw_rise,
    output logic sw_fall
);

    localparam int            CW   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          meta;
    logic          sync;
    logic          state;
    logic [CW-1:0] cnt;

    // Synchroniser flops reset to INIT_VAL (same as sw_stable) so that
    // leaving reset with the pin at its initial level starts no count.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            meta      <= INIT_VAL;
            sync      <= INIT_VAL;
            state     <= ST_IDLE;
            cnt       <= '0;
            sw_stable <= INIT_VAL;
            sw_rise   <= 1'b0;
            sw_fall   <= 1'b0;
        end else begin
            meta    <= sw_raw;
            sync    <= meta;
            sw_rise <= 1'b0;
            sw_fall <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (sync != sw_stable) begin
                        state <= ST_COUNT;
                        cnt   <= CW'(1);
                    end else begin
                        cnt   <= '0;
                    end
                end
                default: begin
                    if (sync == sw_stable) begin
                        // Bounced back before persisting: drop the count.
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else if (cnt == LAST) begin
                        // This is the DEBOUNCE_CYCLES-th consecutive sample.
                        sw_stable <= sync;
                        sw_rise   <= sync;
                        sw_fall   <= ~sync;
                        state     <= ST_IDLE;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/switch_debounce.sv
// Input conditioning for the board slide switches feeding the SoC GPIO.
// Each bit is synchronised and debounced independently; the top level adds
// sticky change flags (write-1-to-clear) and a maskable level interrupt.
//   clk, RSTn   : clock, asynchronous active-low reset
//   sw_raw      : asynchronous switch pins
//   sw_stable   : debounced levels
//   sw_rise     : per-bit 1-cycle pulse on accepted 0->1
//   sw_fall     : per-bit 1-cycle pulse on accepted 1->0
//   chg_pending : sticky per-bit change flags
//   chg_clr     : write-1-to-clear strobes for chg_pending
//   irq_mask    : per-bit interrupt enables
//   irq         : registered |(chg_pending & irq_mask)
module switch_debounce
    import sw_debounce_pkg::*;
#(
    parameter int               WIDTH           = 8,
    parameter int               DEBOUNCE_CYCLES = 500000,
    parameter logic [WIDTH-1:0] INIT_VAL        = 8'h00
) (
    input  logic             clk,
    input  logic             RSTn,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_stable,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic [WIDTH-1:0] chg_pending,
    input  logic [WIDTH-1:0] chg_clr,
    input  logic [WIDTH-1:0] irq_mask,
    output logic             irq
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .INIT_VAL        (INIT_VAL[i])
        ) u_bit (
            .clk       (clk),
            .RSTn      (RSTn),
            .sw_raw    (sw_raw[i]),
            .sw_stable (sw_stable[i]),
            .sw_rise   (sw_rise[i]),
            .sw_fall   (sw_fall[i])
        );
    end

    // Set has priority over clear so an edge arriving with the clear strobe
    // is never lost.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            chg_pending <= '0;
            irq         <= 1'b0;
        end else begin
            chg_pending <= (chg_pending & ~chg_clr) | sw_rise | sw_fall;
            irq         <= |(chg_pending & irq_mask);
        end
    end

endmodule

// File: tb/tb_switch_debounce.sv
module tb_switch_debounce;

    logic       clk = 1'b0;
    logic       RSTn;
    logic [7:0] sw_raw;
    logic [7:0] sw_stable;
    logic [7:0] sw_rise;
    logic [7:0] sw_fall;
    logic [7:0] chg_pending;
    logic [7:0] chg_clr;
    logic [7:0] irq_mask;
    logic       irq;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    switch_debounce #(
        .WIDTH           (8),
        .DEBOUNCE_CYCLES (4),
        .INIT_VAL        (8'h00)
    ) dut (
        .clk         (clk),
        .RSTn        (RSTn),
        .sw_raw      (sw_raw),
        .sw_stable   (sw_stable),
        .sw_rise     (sw_rise),
        .sw_fall     (sw_fall),
        .chg_pending (chg_pending),
        .chg_clr     (chg_clr),
        .irq_mask    (irq_mask),
        .irq         (irq)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges; inputs change and outputs are sampled 1ns after.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [7:0] acc;

    initial begin
        RSTn     = 1'b0;
        sw_raw   = 8'h00;
        chg_clr  = 8'h00;
        irq_mask = 8'h00;
        step(3);

        // 1. reset state, then quiet for 20 cycles
        chk("rst_stable", sw_stable, 8'h00);
        chk("rst_rise",   sw_rise | sw_fall, 8'h00);
        chk("rst_pend",   chg_pending, 8'h00);
        chk("rst_irq",    irq, 1'b0);
        RSTn = 1'b1;
        acc  = 8'h00;
        for (int i = 0; i < 20; i++) begin
            step(1);
            acc |= sw_stable | sw_rise | sw_fall | chg_pending | {7'd0, irq};
        end
        chk("quiet_20", acc, 8'h00);

        // 2. bit 0 rise: accepted exactly 6 cycles after the pin edge
        sw_raw = 8'h01;
        step(5);
        chk("b0_early", sw_stable, 8'h00);
        step(1);
        chk("b0_stable", sw_stable, 8'h01);
        chk("b0_rise",   sw_rise,   8'h01);
        step(1);
        chk("b0_rise_1cyc", sw_rise, 8'h00);
        chk("b0_pend",   chg_pending, 8'h01);
        step(1);
        chk("b0_irq_masked", irq, 1'b0);

        // 3. bounce on bit 3: 3 high, 1 low, 3 high, low -> rejected
        acc = 8'h00;
        sw_raw = 8'h09; step(3); acc |= sw_stable | sw_rise | sw_fall;
        sw_raw = 8'h01; step(1); acc |= sw_stable | sw_rise | sw_fall;
        sw_raw = 8'h09;
        for (int i = 0; i < 3; i++) begin
            step(1);
            acc |= sw_stable | sw_rise | sw_fall;
        end
        sw_raw = 8'h01;
        for (int i = 0; i < 10; i++) begin
            step(1);
            acc |= sw_stable | sw_rise | sw_fall;
        end
        chk("bounce_rej", acc & 8'h08, 8'h00);
        chk("bounce_pend", chg_pending, 8'h01);
        // exactly 4 cycles high -> accepted
        sw_raw = 8'h09;
        step(4);
        sw_raw = 8'h01;
        step(1);
        chk("b3_early", sw_stable, 8'h01);
        step(1);
        chk("b3_stable", sw_stable, 8'h09);
        chk("b3_rise",   sw_rise,   8'h08);
        step(10);   // accepted fall of bit 3 drains
        chk("b3_back", sw_stable, 8'h01);
        chk("b3_pend", chg_pending, 8'h09);
        chg_clr = 8'h08; step(1); chg_clr = 8'h00;
        chk("b3_clr", chg_pending, 8'h01);

        // 4. irq and write-1-to-clear
        irq_mask = 8'h01;
        step(1);
        chk("irq_set", irq, 1'b1);
        chg_clr = 8'h01; step(1); chg_clr = 8'h00;
        chk("clr_pend", chg_pending, 8'h00);
        step(1);
        chk("clr_irq", irq, 1'b0);
        // clear coinciding with sw_fall[0]: set wins
        sw_raw = 8'h00;
        step(6);
        chk("fall0", sw_fall, 8'h01);
        chk("fall0_lvl", sw_stable, 8'h00);
        chg_clr = 8'h01; step(1); chg_clr = 8'h00;
        chk("set_wins", chg_pending, 8'h01);
        step(1);
        chk("irq_again", irq, 1'b1);
        chg_clr = 8'h01; step(1); chg_clr = 8'h00;
        irq_mask = 8'h00;
        step(1);
        chk("irq_off", irq, 1'b0);

        // 5. all bits rise together
        sw_raw = 8'hFF;
        step(5);
        chk("all_early", sw_stable, 8'h00);
        step(1);
        chk("all_stable", sw_stable, 8'hFF);
        chk("all_rise",   sw_rise,   8'hFF);
        chk("all_nofall", sw_fall,   8'h00);
        step(1);
        chk("all_pend", chg_pending, 8'hFF);
        sw_raw = 8'h00;
        step(8);
        chk("all_back", sw_stable, 8'h00);
        chg_clr = 8'hFF; step(1); chg_clr = 8'h00;

        // 6. reset mid-count on bit 5 (cnt reaches 2 at the 4th edge)
        sw_raw = 8'h20;
        step(4);
        RSTn = 1'b0;
        #1;
        chk("mid_rst_stable", sw_stable, 8'h00);
        chk("mid_rst_pulse",  sw_rise | sw_fall, 8'h00);
        step(2);
        RSTn = 1'b1;
        acc = 8'h00;
        for (int i = 0; i < 5; i++) begin
            step(1);
            acc |= sw_stable | sw_rise | sw_fall | chg_pending;
        end
        chk("recount_quiet", acc, 8'h00);
        step(1);
        chk("recount_stable", sw_stable, 8'h20);
        chk("recount_rise",   sw_rise,   8'h20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

endmodule
